// File: rtl/ram_reader.sv
// ram_reader: sweeps a one-bit-wide LUT RAM from address 0 upwards and
// reassembles IO_WIDTH consecutive bits (MSB first) into words. Each completed
// word is registered on out, compared with the expected input, and mismatches
// are counted (saturating). The block never writes the RAM.
// IO_WIDTH must divide 2**ADDR_WIDTH, so that the last address of the sweep is
// also the last bit of a word.
module ram_reader #(
  parameter int IO_WIDTH   = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  ram_out,
  input  logic [IO_WIDTH-1:0]   expected,
  output logic [IO_WIDTH-1:0]   out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            mismatch_count
);

  // A one-bit word still needs a one-bit counter that stays at zero.
  localparam int BW = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [IO_WIDTH-1:0] shreg;
  logic [IO_WIDTH-1:0] word_next;
  logic [BW-1:0]       bit_cnt;
  logic                word_last;
  logic                addr_last;

  // Shifting in from the LSB side, written so that IO_WIDTH = 1 stays legal.
  assign word_next = (shreg << 1) | IO_WIDTH'(ram_out);
  assign word_last = (bit_cnt == BW'(IO_WIDTH - 1));
  assign addr_last = (addr == {ADDR_WIDTH{1'b1}});
  assign busy      = (state == SWEEP);
  assign done      = (state == DONE);

  // State register; reset always returns to IDLE, overriding any start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: start only matters in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SWEEP;
      SWEEP:   if (addr_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: address sweep, bit shifting, word output and mismatch counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr           <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      out            <= '0;
      out_valid      <= 1'b0;
      mismatch_count <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          addr <= '0;
          if (start) begin
            shreg          <= '0;
            bit_cnt        <= '0;
            mismatch_count <= '0;
          end
        end
        SWEEP: begin
          addr  <= addr + ADDR_WIDTH'(1);
          shreg <= word_next;
          if (word_last) begin
            bit_cnt   <= '0;
            out       <= word_next;
            out_valid <= 1'b1;
            if ((word_next != expected) && (mismatch_count != 8'hFF))
              mismatch_count <= mismatch_count + 8'd1;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DONE: begin
          addr <= '0;
        end
        default: begin
          addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: randomized and directed checks of ram_reader.
// Instance A (16-bit words, 64 bits) is checked by a scoreboard; instance B
// (8-bit words) reads an all-ones RAM; instance C (1-bit words, 256 bits)
// runs 300 back-to-back sweeps to exercise mismatch saturation.
`timescale 1ns/1ps
module tb_ram_reader;

  localparam int W     = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks  = 0;
  int passed_checks = 0;

  // ---------------- instance A ----------------
  logic          rst_a, start_a, ram_out_a, out_valid_a, busy_a, done_a;
  logic [AW-1:0] addr_a;
  logic [W-1:0]  expected_a, out_a;
  logic [7:0]    mm_a;
  logic          mem_a [DEPTH];
  logic [W-1:0]  ref_words [WORDS];
  logic [1:0]    word_idx_a;
  bit            match_mode = 1'b1;

  assign word_idx_a = addr_a[AW-1:4];
  assign ram_out_a  = mem_a[addr_a];
  assign expected_a = match_mode ? ref_words[word_idx_a] : '0;

  ram_reader #(.IO_WIDTH(W), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .addr(addr_a), .ram_out(ram_out_a),
    .expected(expected_a), .out(out_a), .out_valid(out_valid_a), .busy(busy_a),
    .done(done_a), .mismatch_count(mm_a)
  );

  // ---------------- instance B ----------------
  logic       rst_bc, start_b, out_valid_b, busy_b, done_b;
  logic [5:0] addr_b;
  logic [7:0] out_b, mm_b;

  ram_reader #(.IO_WIDTH(8), .ADDR_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst_bc), .start(start_b), .addr(addr_b), .ram_out(1'b1),
    .expected(8'h00), .out(out_b), .out_valid(out_valid_b), .busy(busy_b),
    .done(done_b), .mismatch_count(mm_b)
  );

  // ---------------- instance C ----------------
  logic       start_c, ram_out_c, expected_c, out_c, out_valid_c, busy_c, done_c;
  logic [7:0] addr_c, mm_c;
  logic       mem_c [256];

  assign ram_out_c  = mem_c[addr_c];
  assign expected_c = ~mem_c[addr_c];

  ram_reader #(.IO_WIDTH(1), .ADDR_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst_bc), .start(start_c), .addr(addr_c), .ram_out(ram_out_c),
    .expected(expected_c), .out(out_c), .out_valid(out_valid_c), .busy(busy_c),
    .done(done_c), .mismatch_count(mm_c)
  );

  // ---------------- scoreboard for A ----------------
  typedef struct {
    logic [W-1:0] word;
    int           cyc;
    bit           last;
  } exp_t;

  exp_t         exp_q [$];
  int           mm_q [$];
  int           cyc_a      = 0;
  logic         prev_busy_a = 1'b0;
  int           stray_a    = 0;
  logic [W-1:0] hold_word  = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total_checks++;
    if (actual === required) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
  endtask

  // Monitor: pops the scoreboard on every out_valid of instance A.
  always @(negedge clk) begin
    exp_t e;
    if (busy_a && !prev_busy_a) cyc_a = 0;
    else                        cyc_a++;
    prev_busy_a = busy_a;
    if (out_valid_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        stray_a++;
      end else begin
        e = exp_q.pop_front();
        checkOutput("a_out_word", 32'(out_a), 32'(e.word));
        checkOutput("a_out_valid_cycle", 32'(cyc_a), 32'(e.cyc));
        checkOutput("a_done_with_last", 32'(done_a), 32'(e.last));
        hold_word = e.word;
        if (e.last && mm_q.size() > 0)
          checkOutput("a_mismatch_count", 32'(mm_a), 32'(mm_q.pop_front()));
      end
    end else if (done_a === 1'b1) begin
      stray_a++;
    end else if (busy_a === 1'b1) begin
      checkOutput("a_out_hold", 32'(out_a), 32'(hold_word));
    end
  end

  // Reference model: word k holds bits k*W .. k*W+W-1, lowest address is MSB.
  task automatic buildWords();
    for (int k = 0; k < WORDS; k++)
      for (int i = 0; i < W; i++)
        ref_words[k][W-1-i] = mem_a[k*W + i];
  endtask

  task automatic loadWords(input logic [WORDS*W-1:0] ws);
    for (int k = 0; k < WORDS; k++) begin
      ref_words[k] = ws[(WORDS-1-k)*W +: W];
      for (int i = 0; i < W; i++) mem_a[k*W + i] = ref_words[k][W-1-i];
    end
  endtask

  task automatic randomMem();
    for (int i = 0; i < DEPTH; i++) mem_a[i] = 1'($urandom_range(0, 1));
    buildWords();
  endtask

  task automatic queueSweep();
    int mm = 0;
    for (int k = 0; k < WORDS; k++) begin
      exp_t e;
      e.word = ref_words[k];
      e.cyc  = (k + 1) * W;
      e.last = (k == WORDS - 1);
      exp_q.push_back(e);
      if (!match_mode && ref_words[k] != '0) mm++;
    end
    mm_q.push_back(mm);
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic waitDoneA(input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (done_a === 1'b1) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic runA();
    int stray_snap;
    rst_a = 1'b1; start_a = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_a[i] = 1'b0;
    buildWords();
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    checkOutput("reset_addr", 32'(addr_a), 32'd0);
    checkOutput("reset_out", 32'(out_a), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid_a), 32'd0);
    checkOutput("reset_busy", 32'(busy_a), 32'd0);
    checkOutput("reset_done", 32'(done_a), 32'd0);
    checkOutput("reset_mismatch", 32'(mm_a), 32'd0);

    $display("[TB] directed sweep, matching expected");
    loadWords({16'hA5C3, 16'h1234, 16'hFFFF, 16'h0000});
    match_mode = 1'b1;
    queueSweep();
    applyStimulus();
    waitDoneA("a_done_match");
    checkOutput("a_mm_match_zero", 32'(mm_a), 32'd0);

    $display("[TB] directed sweep, expected constant zero");
    match_mode = 1'b0;
    queueSweep();
    applyStimulus();
    waitDoneA("a_done_zero");
    checkOutput("a_mm_zero_three", 32'(mm_a), 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("a_mm_hold_idle", 32'(mm_a), 32'd3);

    $display("[TB] reset during sweep");
    randomMem();
    match_mode = 1'($urandom_range(0, 1));
    queueSweep();
    applyStimulus();
    repeat (20) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    exp_q.delete();
    mm_q.delete();
    hold_word = '0;
    stray_snap = stray_a;
    @(negedge clk);
    checkOutput("abort_addr", 32'(addr_a), 32'd0);
    checkOutput("abort_out", 32'(out_a), 32'd0);
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_mismatch", 32'(mm_a), 32'd0);
    repeat (80) @(negedge clk);
    checkOutput("abort_no_pulses", 32'(stray_a), 32'(stray_snap));

    $display("[TB] start held high across a sweep");
    randomMem();
    match_mode = 1'($urandom_range(0, 1));
    queueSweep();
    queueSweep();
    @(posedge clk); #1 start_a = 1'b1;
    waitDoneA("a_done_held1");
    @(negedge clk);
    checkOutput("held_idle_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    checkOutput("held_restart_busy", 32'(busy_a), 32'd1);
    checkOutput("held_restart_addr", 32'(addr_a), 32'd0);
    checkOutput("held_restart_mm", 32'(mm_a), 32'd0);
    start_a = 1'b0;
    waitDoneA("a_done_held2");
    repeat (4) @(negedge clk);
    checkOutput("held_single_restart", 32'(busy_a), 32'd0);

    $display("[TB] random sweeps");
    for (int s = 0; s < 8; s++) begin
      randomMem();
      match_mode = 1'($urandom_range(0, 1));
      queueSweep();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      applyStimulus();
      waitDoneA("a_done_random");
    end
    repeat (4) @(negedge clk);
    checkOutput("a_queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("a_stray_pulses", 32'(stray_a), 32'd0);
  endtask

  task automatic runB();
    int pulses = 0;
    bit seen   = 1'b0;
    int n      = 0;
    start_b = 1'b0;
    repeat (4) @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid_b === 1'b1) begin
        pulses++;
        checkOutput("b_word", 32'(out_b), 32'hFF);
      end
      if (done_b === 1'b1) seen = 1'b1;
    end
    checkOutput("b_done_seen", 32'(seen), 32'd1);
    checkOutput("b_pulses", 32'(pulses), 32'd8);
    checkOutput("b_mismatch", 32'(mm_b), 32'd8);
    checkOutput("b_busy_in_done", 32'(busy_b), 32'd0);
  endtask

  task automatic runC();
    for (int i = 0; i < 256; i++) mem_c[i] = 1'($urandom_range(0, 1));
    start_c = 1'b0;
    repeat (4) @(posedge clk);
    #1 start_c = 1'b1;
    for (int s = 0; s < 300; s++) begin
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 10) begin
        @(negedge clk);
        n++;
        if (busy_c === 1'b1 && addr_c == 8'd0) seen = 1'b1;
      end
      checkOutput("c_sweep_start", 32'(seen), 32'd1);
      if (s == 299) start_c = 1'b0;
      checkOutput("c_mm_cleared", 32'(mm_c), 32'd0);
      repeat (100) @(negedge clk);
      checkOutput("c_mm_mid", 32'(mm_c), 32'd100);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 300) begin
        @(negedge clk);
        n++;
        if (done_c === 1'b1) seen = 1'b1;
      end
      checkOutput("c_done_seen", 32'(seen), 32'd1);
      checkOutput("c_mm_saturated", 32'(mm_c), 32'd255);
      checkOutput("c_last_bit", 32'(out_c), 32'(mem_c[255]));
    end
  endtask

  initial begin
    rst_bc  = 1'b1;
    start_b = 1'b0;
    start_c = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_bc = 1'b0;
    fork
      runA();
      runB();
      runC();
    join
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
